// File: rtl/argmax_sequencer.sv
// Final classification stage: streams NUM_CLASSES scores, tracks the running
// maximum and its class index, and presents the winning digit on a valid/ready port.
module argmax_sequencer #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SCORE_W-1:0] s_score,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [3:0]         digit,
  output logic [SCORE_W-1:0] max_score,
  output logic               busy,
  output logic [15:0]        frames_done
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESOLVE,
    HOLD
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t               state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [SCORE_W-1:0]   run_max_q, run_max_d;
  logic [3:0]           run_idx_q, run_idx_d;
  logic [3:0]           digit_q, digit_d;
  logic [SCORE_W-1:0]   max_score_q, max_score_d;
  logic                 d_valid_q, d_valid_d;
  logic [15:0]          frames_done_q, frames_done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      digit_q       <= '0;
      max_score_q   <= '0;
      d_valid_q     <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      digit_q       <= digit_d;
      max_score_q   <= max_score_d;
      d_valid_q     <= d_valid_d;
      frames_done_q <= frames_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    digit_d       = digit_q;
    max_score_d   = max_score_q;
    d_valid_d     = d_valid_q;
    frames_done_d = frames_done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          count_d   = '0;
          run_max_d = '0;
          run_idx_d = '0;
        end
      end
      COLLECT: begin
        // A start here aborts the image; a same-cycle beat is deliberately dropped.
        if (start) begin
          count_d   = '0;
          run_max_d = '0;
          run_idx_d = '0;
        end else if (s_valid) begin
          if ((s_score > run_max_q) || (count_q == '0)) begin
            run_max_d = s_score;
            run_idx_d = count_q;
          end
          count_d = count_q + 4'd1;
          if (count_q == LAST_IDX) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        digit_d     = run_idx_q;
        max_score_d = run_max_q;
        d_valid_d   = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (d_ready) begin
          d_valid_d     = 1'b0;
          frames_done_d = frames_done_q + 16'd1;
          if (start) begin
            state_d   = COLLECT;
            count_d   = '0;
            run_max_d = '0;
            run_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready     = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign d_valid     = d_valid_q;
  assign digit       = digit_q;
  assign max_score   = max_score_q;
  assign frames_done = frames_done_q;

endmodule

// File: doc/argmax_sequencer.md
# argmax_sequencer

Sequences the final classification step of the MNIST inference datapath. It accepts the ten output-layer scores as an in-order stream, one per handshake, and tracks the running maximum and its class index. It then presents the winning digit on a valid/ready result port and holds it until the downstream consumer (display/UART formatter) takes it. It sits between the output-layer MAC engine and the result sink, and it owns the per-image start/abort sequencing of that boundary.

## Interface
- NUM_CLASSES, 10, number of scores per image; index width fixed at 4 bits, so legal range is 2..16
- SCORE_W, 8, unsigned score width
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a new image
- s_valid  in  1  score stream valid
- s_ready  out  1  score stream ready; high exactly when state is COLLECT
- s_score  in  SCORE_W  unsigned score; class index is implied by arrival order 0..NUM_CLASSES-1
- d_valid  out  1  result valid
- d_ready  in  1  result ready
- digit  out  4  index of the maximum score
- max_score  out  SCORE_W  value of the maximum score
- busy  out  1  high in COLLECT, RESOLVE and HOLD
- frames_done  out  16  count of results consumed; wraps 0xFFFF to 0x0000

## Operation
- States: IDLE, COLLECT, RESOLVE, HOLD.
- IDLE:
  - s_ready=0 and d_valid=0.
  - start=1 -> COLLECT. This clears count, run_max and run_idx.
  - s_valid is ignored.
- COLLECT:
  - On accept (s_valid & s_ready), compare s_score > run_max, or count==0. If true, load run_max=s_score and run_idx=count. Then count++.
  - Ties keep the earlier index, so the lowest index wins.
  - The comparison is full SCORE_W-bit unsigned.
  - The accept with count==NUM_CLASSES-1 -> RESOLVE.
  - start=1 in COLLECT aborts the image and restarts COLLECT with count=0. Any same-cycle s_valid beat is dropped, not counted.
- RESOLVE (one cycle): register digit=run_idx and max_score=run_max, then -> HOLD.
- HOLD:
  - d_valid=1. digit and max_score are stable until the handshake.
  - On d_valid & d_ready, frames_done++.
  - Next state is COLLECT (with count cleared) if start=1 in the same cycle, else IDLE.
  - start without d_ready in HOLD is ignored (no queuing).
- digit and max_score keep the last result after the handshake. They update only in RESOLVE.
- Reset (rst_n=0 at an edge), from any state including mid-COLLECT or HOLD:
  - State -> IDLE.
  - s_ready=0, d_valid=0, busy=0.
  - digit=0, max_score=0, frames_done=0.
  - count, run_max and run_idx are cleared.
  - Any pending result is discarded.

## Timing
- s_ready and busy are decoded combinationally from the state register. d_valid, digit, max_score and frames_done are registers.
- Start to first acceptable beat: start sampled at edge E; s_ready=1 from E.
- Full-rate stream: 10 consecutive accepts, one per cycle, with no bubbles required.
- Latency from the final accept (edge N) to the result:
  - RESOLVE during cycle N..N+1.
  - digit and max_score valid from edge N+1; d_valid=1 from edge N+1.
- Minimum image period at full rate with d_ready held 1: 1 start cycle + 10 beats + RESOLVE + HOLD = 13 cycles. Back-to-back operation is possible via start in the HOLD handshake cycle, giving 12 cycles.
- frames_done increments at the edge that completes the d handshake.

## Test plan
- **Basic max:** reset, then start, then scores 3,7,1,200,9,0,5,199,4,2 at full rate, d_ready=1.
  - Required: digit=3, max_score=200.
  - d_valid rises 1 cycle after the 10th accept.
  - frames_done=1.
- **Ties and endpoints:**
  - Scores all 0x55: digit=0.
  - Scores 0..8 = 10, score 9 = 11: digit=9.
  - Scores 0 = 255, 9 = 255, rest 0: digit=0.
- **Backpressure and bubbles:**
  - Randomly toggle s_valid; hold d_ready=0 for 20 cycles.
  - Required: d_valid stays 1 and digit/max_score stay stable through the stall.
  - s_ready=0 throughout RESOLVE and HOLD.
  - No extra beats are accepted.
- **Abort and back-to-back:**
  - Assert start after 4 beats, then send a fresh 10-score image (max at index 6). Required: digit=6, with the first 4 beats discarded.
  - Assert start in the HOLD handshake cycle. Required: the next image is collected without an IDLE cycle.
- **Reset mid-operation and wrap:**
  - Assert rst_n=0 after 5 beats. Required: state IDLE, all outputs 0, and no result is emitted.
  - Force frames_done to 0xFFFF, then complete one frame. Required: frames_done=0x0000.
